// File: rtl/seq_booth_mul_if.sv
// Handshake and operand/result bundle for the sequential Booth multiplier.
// The master side issues requests; the slave side (the multiplier) answers them.
interface seq_booth_mul_if #(
  parameter int WIDTH = 6
);
  logic               start;
  logic               signed_mode;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] out;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, out
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, out
  );
endinterface

// File: rtl/seq_booth_mul.sv
// Multi-cycle radix-2 Booth multiplier: WIDTH+1 add/shift steps per product,
// runtime signed/unsigned operands, start/done handshake, registered result.
module seq_booth_mul #(
  parameter int WIDTH = 6
) (
  input  logic           clk,
  input  logic           rst,
  seq_booth_mul_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH+1:0]   acc;      // A: partial product with one guard bit
  logic [WIDTH+1:0]   mcand;    // M: extended multiplicand
  logic [WIDTH:0]     q;        // Q: extended multiplier, shifted out step by step
  logic               q_m1;     // Booth bit q(-1)
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] out_q;

  logic               last_step;
  logic               accept;
  logic [WIDTH+1:0]   a_sum;
  logic [WIDTH+1:0]   acc_n;
  logic [WIDTH:0]     q_n;
  logic               a_ext;
  logic               b_ext;

  assign last_step = (cnt == CNT_W'(WIDTH));
  assign accept    = bus.start && (state_q != CALC);
  assign a_ext     = bus.signed_mode & bus.a[WIDTH-1];
  assign b_ext     = bus.signed_mode & bus.b[WIDTH-1];

  // One Booth step: conditional add/subtract, then arithmetic shift of {A,Q,q(-1)}.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    a_sum = acc;
    unique case ({q[0], q_m1})
      2'b01:   a_sum = acc + mcand;
      2'b10:   a_sum = acc - mcand;
      default: a_sum = acc;
    endcase
    acc_n = {a_sum[WIDTH+1], a_sum[WIDTH+1:1]};
    q_n   = {a_sum[0], q[WIDTH:1]};
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = CALC;
      CALC:    if (last_step) state_d = DONE;
      DONE:    state_d = bus.start ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == CALC);
    bus.done = (state_q == DONE);
    bus.out  = out_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      mcand <= '0;
      q     <= '0;
      q_m1  <= 1'b0;
      cnt   <= '0;
      out_q <= '0;
    end else if (accept) begin
      acc   <= '0;
      mcand <= {{2{a_ext}}, bus.a};
      q     <= {b_ext, bus.b};
      q_m1  <= 1'b0;
      cnt   <= '0;
    end else if (state_q == CALC) begin
      acc  <= acc_n;
      q    <= q_n;
      q_m1 <= q[0];
      cnt  <= cnt + 1'b1;
      // Low 2*WIDTH bits of the product as it stands after this final shift.
      if (last_step) out_q <= {acc_n[WIDTH-2:0], q_n};
    end
  end

endmodule

// File: tb/tb_seq_booth_mul.sv
// Self-checking bench for seq_booth_mul (WIDTH=6): directed vector table,
// handshake/latency, back-to-back, mid-operation reset and a full operand sweep.
module tb_seq_booth_mul;

  localparam int W = 6;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  seq_booth_mul_if #(.WIDTH(W)) bus ();

  seq_booth_mul #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          smode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2*W-1:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent golden model: integer product masked to 2*W bits.
  function automatic logic [2*W-1:0] golden(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
    int x, y;
    x = s ? {{(32-W){a[W-1]}}, a} : {{(32-W){1'b0}}, a};
    y = s ? {{(32-W){b[W-1]}}, b} : {{(32-W){1'b0}}, b};
    return (2*W)'(x * y);
  endfunction

  // Issue one operation from the current (post-edge) time and wait for done.
  task automatic run_op(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [2*W-1:0] res);
    int n;
    n = 0;
    while (bus.busy && n < 20) begin
      tick();
      n++;
    end
    bus.start       = 1'b1;
    bus.signed_mode = s;
    bus.a           = a;
    bus.b           = b;
    tick();
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 20) begin
      tick();
      n++;
    end
    if (!bus.done) check("done_timeout", 32'(n), 32'(W + 1));
    res = bus.out;
  endtask

  initial begin
    vec_t vecs[10];
    logic [2*W-1:0] res;
    int edges;
    bit saw_done;

    total = 0;
    bad   = 0;
    vecs[0] = '{1'b1, 6'h20, 6'h20, 12'h400};
    vecs[1] = '{1'b1, 6'h3F, 6'h01, 12'hFFF};
    vecs[2] = '{1'b1, 6'h1F, 6'h20, 12'hC20};
    vecs[3] = '{1'b0, 6'h3F, 6'h3F, 12'hF81};
    vecs[4] = '{1'b0, 6'h20, 6'h02, 12'h040};
    vecs[5] = '{1'b1, 6'h05, 6'h3D, 12'hFF1};
    vecs[6] = '{1'b0, 6'h05, 6'h3D, 12'h131};
    vecs[7] = '{1'b1, 6'h3F, 6'h3F, 12'h001};
    vecs[8] = '{1'b1, 6'h00, 6'h2A, 12'h000};
    vecs[9] = '{1'b0, 6'h2A, 6'h03, 12'h07E};

    bus.start       = 1'b0;
    bus.signed_mode = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    rst             = 1'b1;
    repeat (3) tick();
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_out",  32'(bus.out),  32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].smode, vecs[i].a, vecs[i].b, res);
      check($sformatf("vec%0d", i), 32'(res), 32'(vecs[i].exp));
    end
    tick();
    tick();

    // Latency/handshake with start held through CALC and operands changed mid-run.
    bus.start = 1'b1; bus.signed_mode = 1'b0; bus.a = 6'd3; bus.b = 6'd5;
    tick();
    bus.signed_mode = 1'b1; bus.a = 6'h3F; bus.b = 6'h3F;
    for (int k = 0; k <= W; k++) begin
      check($sformatf("lat_busy%0d", k), 32'(bus.busy), 32'd1);
      check($sformatf("lat_done%0d", k), 32'(bus.done), 32'd0);
      if (k == W) bus.start = 1'b0;
      tick();
    end
    check("lat_done_pulse", 32'(bus.done), 32'd1);
    check("lat_busy_off",   32'(bus.busy), 32'd0);
    check("lat_result",     32'(bus.out),  32'h00F);
    tick();
    check("lat_done_clear", 32'(bus.done), 32'd0);
    check("lat_idle_busy",  32'(bus.busy), 32'd0);

    // Back-to-back: new start accepted during the DONE cycle.
    run_op(1'b0, 6'h2A, 6'h03, res);
    check("b2b_first", 32'(res), 32'h07E);
    bus.start = 1'b1; bus.signed_mode = 1'b1; bus.a = 6'h05; bus.b = 6'h3D;
    tick();
    bus.start = 1'b0;
    check("b2b_busy", 32'(bus.busy), 32'd1);
    check("b2b_out_held", 32'(bus.out), 32'h07E);
    edges = 1;
    while (!bus.done && edges < 20) begin
      tick();
      edges++;
    end
    check("b2b_spacing", 32'(edges), 32'(W + 2));
    check("b2b_second",  32'(bus.out), 32'hFF1);

    // Reset in the middle of an operation.
    tick();
    bus.start = 1'b1; bus.signed_mode = 1'b0; bus.a = 6'd7; bus.b = 6'd9;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    check("mid_rst_out",  32'(bus.out),  32'd0);
    tick();
    rst = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    check("mid_rst_no_done", 32'(saw_done), 32'd0);
    run_op(1'b0, 6'd7, 6'd9, res);
    check("mid_rst_recover", 32'(res), 32'h03F);

    // Full sweep, both modes, back-to-back issue.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < (1 << W); i++) begin
        for (int j = 0; j < (1 << W); j++) begin
          run_op(s[0], W'(i), W'(j), res);
          check($sformatf("sweep s=%0d a=%0d b=%0d", s, i, j), 32'(res),
                32'(golden(s[0], W'(i), W'(j))));
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_booth_mul.md
Name: seq_booth_mul

Overview:
- Parametrised, multi-cycle radix-2 Booth multiplier with a start/done handshake.
- Successor to the combinational mul_top array multiplier. Trades latency for area and adds runtime signed/unsigned selection.
- Sits on the datapath between the operand registers and the result bus.
- Produces the full 2*WIDTH-bit product with the same low-2*WIDTH-bit semantics as mul_top: two's-complement product masked to 2*WIDTH bits.

Parameters:
- WIDTH, 6, operand width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+2), iteration counter width; derived, never overridden.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  request a multiply; sampled when not busy.
- signed_mode  input  1  1 = operands are two's complement; 0 = operands are unsigned. Sampled with start.
- a  input  WIDTH  multiplicand; sampled with start.
- b  input  WIDTH  multiplier; sampled with start.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse: out holds a new result.
- out  output  2*WIDTH  product register.

Behaviour:
- Reset (rst=1, any time, asynchronous):
  - State goes to IDLE.
  - busy=0, done=0, out=0, counter=0, internal accumulator=0.
  - An operation in flight is discarded. No done pulse follows deassertion.
- States: IDLE, CALC, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 at edge N:
    - Latch a and b, extended to WIDTH+1 bits: sign-extended if signed_mode=1, zero-extended if 0.
    - Clear the accumulator, Booth bit q(-1)=0 and counter=0.
    - Go to CALC.
  - start=0: stay in IDLE.
- CALC:
  - busy=1. One Booth step per edge:
    - Inspect {q0, q(-1)}: 01 adds M, 10 subtracts M, 00 and 11 do nothing.
    - Then arithmetic-shift {A,Q,q(-1)} right by one.
    - A and M are WIDTH+2 bits wide, giving one guard bit.
    - Increment counter.
  - Exactly WIDTH+1 steps are taken, on edges N+1 .. N+WIDTH+1.
  - On the final step, load out with the low 2*WIDTH bits of the 2*WIDTH+2-bit product and go to DONE.
- DONE:
  - done=1, busy=0 for exactly one cycle.
  - start=1 in DONE is accepted as in IDLE (back-to-back operation) and goes to CALC. Otherwise go to IDLE.
- Latency: done is high during the cycle after edge N+WIDTH+1. For WIDTH=6 that is 7 edges after the start edge.
- Throughput: one result per WIDTH+2 cycles back-to-back.
- start while busy=1 is ignored. Operand and mode changes during CALC have no effect.
- out holds its value from the final step until the next final step or reset. It does not clear on start.
- Arithmetic:
  - The result equals (a*b) mod 2^(2*WIDTH), with a and b interpreted per signed_mode.
  - The product is exact in both modes; the signed extreme -2^(WIDTH-1) squared = 2^(2*WIDTH-2) fits.
- No combinational path from any input to any output.

Test Plan:
- Signed corners, WIDTH=6, signed_mode=1:
  - a=6'b100000 (-32), b=6'b100000 -> out=12'h400.
  - a=6'b111111 (-1), b=6'b000001 -> out=12'hFFF.
  - a=6'b011111 (31), b=6'b100000 (-32) -> out=12'hC20.
- Unsigned mode, signed_mode=0:
  - a=63, b=63 -> out=12'hF81.
  - a=32, b=2 -> out=12'h040.
- Latency and handshake:
  - start pulse at edge N -> busy high for edges N+1..N+WIDTH+1.
  - done high for exactly one cycle after edge N+7 (WIDTH=6).
  - start held high through CALC -> no restart and no change to the latched operands.
- Back-to-back: start=1 during the DONE cycle with a=5, b=-3 -> the second result 12'hFF1 follows WIDTH+2 cycles after the first done.
- Reset mid-operation: assert rst at edge N+3 between edges -> busy, done and out go to 0 immediately; no done pulse afterwards; the next start completes normally.
- Exhaustive sweep, WIDTH=6: all 64x64 operand pairs in both modes against the golden (a*b)&4095 -> zero mismatches reported.
